// File: rtl/canvas_pkg.sv
// canvas_pkg
//   Shared constants and types for the canvas snapshot path: frame geometry,
//   word widths, the streamer state encoding, the skid-buffer payload, and the
//   accumulator-to-pixel saturating conversion.
//   No ports (package).
package canvas_pkg;

  localparam int CANVAS_DIM = 28;
  localparam int N_PIX      = CANVAS_DIM * CANVAS_DIM;
  localparam int PIX_ADDR_W = $clog2(N_PIX);
  localparam int IN_W       = 16;
  localparam int OUT_W      = 8;
  localparam int SHIFT      = 8;

  typedef logic [PIX_ADDR_W-1:0] pix_addr_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } stream_state_t;

  typedef struct packed {
    logic             last;
    logic [OUT_W-1:0] data;
  } px_entry_t;

  localparam pix_addr_t       LAST_ADDR = pix_addr_t'(N_PIX - 1);
  // One past the last address; N_PIX still fits in PIX_ADDR_W bits.
  localparam pix_addr_t       ISSUE_END = pix_addr_t'(N_PIX);
  localparam logic [IN_W-1:0] PX_MAX    = IN_W'((1 << OUT_W) - 1);

  // Scale the accumulator down and clamp to full-scale white.
  function automatic logic [OUT_W-1:0] sat_pixel(input logic [IN_W-1:0] word);
    logic [IN_W-1:0] t;
    t = word >> SHIFT;
    if (t > PX_MAX) sat_pixel = '1;
    else            sat_pixel = t[OUT_W-1:0];
  endfunction

endpackage

// File: rtl/pixel_skid_buffer.sv
// pixel_skid_buffer
//   Two-entry FIFO between the canvas RAM read pipe and the pixel stream.
//   Output payload comes straight from storage registers, so it stays put
//   while the consumer stalls. Simultaneous push and pop keeps occupancy and
//   order.
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   in_valid/ready  write side ({last, data} payload on in_data)
//   out_valid/ready read side, head entry on out_data
//   count           current occupancy (0..2), used for read-issue credit
module pixel_skid_buffer
  import canvas_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  px_entry_t  in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output px_entry_t  out_data,
  output logic [1:0] count
);

  px_entry_t  mem_q [2];
  px_entry_t  mem_d [2];
  logic       rd_ptr_q, rd_ptr_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic [1:0] count_q, count_d;
  logic       push, pop;

  assign out_valid = (count_q != 2'd0);
  // When full, a pop in the same cycle frees the head slot for the push.
  assign in_ready  = (count_q != 2'd2) | out_ready;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_data  = mem_q[rd_ptr_q];
  assign count     = count_q;

  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = in_data;
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    count_d  = count_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/canvas_streamer.sv
// canvas_streamer
//   Snapshots the 28x28 canvas RAM: on Start, reads every accumulator in
//   address order, converts it to a saturated 8-bit pixel and streams it over
//   valid/ready. Hold freezes the canvas editor while the snapshot runs.
// Ports
//   Clk, Reset         clock, asynchronous active-high reset
//   Start              begin a frame (only honoured in IDLE)
//   Busy, Hold         high from the cycle after Start through the Done cycle
//   Done               one-cycle pulse after the last pixel handshake
//   rd_en, rd_addr     canvas RAM read request (data returns one cycle later)
//   rd_data            canvas RAM read data
//   px_data, px_valid,
//   px_ready, px_last  pixel stream; px_last marks pixel N_PIX-1
//
// state  | meaning
// IDLE   | waiting for Start, no reads
// STREAM | issuing reads and draining pixels until the last one is accepted
// DONE   | single-cycle Done pulse, then back to IDLE
module canvas_streamer
  import canvas_pkg::*;
(
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Start,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Hold,
  output logic                  rd_en,
  output logic [PIX_ADDR_W-1:0] rd_addr,
  input  logic [IN_W-1:0]       rd_data,
  output logic [OUT_W-1:0]      px_data,
  output logic                  px_valid,
  input  logic                  px_ready,
  output logic                  px_last
);

  stream_state_t state_q, state_d;
  pix_addr_t     issue_cnt_q, issue_cnt_d;
  pix_addr_t     addr_q, addr_d;
  logic          inflight_q, inflight_d;
  logic          inflight_last_q, inflight_last_d;

  logic [1:0]    buf_count;
  logic          buf_in_ready;
  logic          pop;
  logic [2:0]    pending;
  px_entry_t     in_entry;
  px_entry_t     out_entry;

  assign pop = px_valid & px_ready;

  // Slots already claimed once this cycle's handshake is taken into account.
  // Counting the pop lets a new read overlap the pixel leaving, which keeps
  // the stream at one pixel per cycle with only two slots of storage.
  assign pending = 3'(buf_count) + 3'(inflight_q) - 3'(pop);

  always_comb begin
    state_d         = state_q;
    issue_cnt_d     = issue_cnt_q;
    addr_d          = addr_q;
    inflight_d      = 1'b0;
    inflight_last_d = 1'b0;
    rd_en           = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start) begin
          state_d     = STREAM;
          issue_cnt_d = '0;
        end
      end
      STREAM: begin
        if ((issue_cnt_q < ISSUE_END) && (pending < 3'd2)) begin
          rd_en           = 1'b1;
          addr_d          = issue_cnt_q;
          issue_cnt_d     = issue_cnt_q + pix_addr_t'(1);
          inflight_d      = 1'b1;
          inflight_last_d = (issue_cnt_q == LAST_ADDR);
        end
        if (pop && px_last) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q         <= IDLE;
      issue_cnt_q     <= '0;
      addr_q          <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      issue_cnt_q     <= issue_cnt_d;
      addr_q          <= addr_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
    end
  end

  // Present the new address with rd_en; otherwise hold the last one issued.
  assign rd_addr = rd_en ? issue_cnt_q : addr_q;

  assign Busy = (state_q != IDLE);
  assign Hold = Busy;
  assign Done = (state_q == DONE);

  assign in_entry.last = inflight_last_q;
  assign in_entry.data = sat_pixel(rd_data);

  // The read credit already guarantees room; gating on in_ready only keeps
  // the write side a proper handshake.
  pixel_skid_buffer u_skid (
    .clk       (Clk),
    .rst       (Reset),
    .in_valid  (inflight_q & buf_in_ready),
    .in_ready  (buf_in_ready),
    .in_data   (in_entry),
    .out_valid (px_valid),
    .out_ready (px_ready),
    .out_data  (out_entry),
    .count     (buf_count)
  );

  assign px_data = out_entry.data;
  assign px_last = out_entry.last;

endmodule

// File: tb/tb_canvas_streamer.sv
module tb_canvas_streamer;
  import canvas_pkg::*;

  logic                  Clk = 1'b0;
  logic                  Reset;
  logic                  Start;
  logic                  Busy, Done, Hold;
  logic                  rd_en;
  logic [PIX_ADDR_W-1:0] rd_addr;
  logic [IN_W-1:0]       rd_data;
  logic [OUT_W-1:0]      px_data;
  logic                  px_valid;
  logic                  px_ready;
  logic                  px_last;

  always #5 Clk = ~Clk;

  canvas_streamer dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Start    (Start),
    .Busy     (Busy),
    .Done     (Done),
    .Hold     (Hold),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .px_data  (px_data),
    .px_valid (px_valid),
    .px_ready (px_ready),
    .px_last  (px_last)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Canvas RAM model: one-cycle read latency.
  logic [IN_W-1:0] ram [N_PIX];
  always @(posedge Clk) if (rd_en) rd_data <= ram[rd_addr];

  // Reference conversion from the arithmetic rule, not the RTL.
  function automatic int ref_px(input int word);
    int t;
    t = word / (1 << SHIFT);
    return (t > (1 << OUT_W) - 1) ? (1 << OUT_W) - 1 : t;
  endfunction

  // px_ready driver: 0 = always ready, 1 = random ~30% duty, 2 = held low.
  int ready_mode = 0;
  always @(negedge Clk) begin
    case (ready_mode)
      0:       px_ready = 1'b1;
      1:       px_ready = ($urandom_range(99) < 30);
      default: px_ready = 1'b0;
    endcase
  end

  // Monitor: samples 2 time units after the falling edge (3 before rising).
  typedef struct { int d; bit l; } cap_t;
  cap_t cap_q[$];
  int   issued, accepted, valid_cycles, first_valid_cyc, last_hs_cyc, done_cyc, done_cnt;
  int   ncyc = 0;
  int   last_addr = 0;
  bit   mon_hs;
  bit   stall_prev = 0;
  int   stall_d;
  bit   stall_l;

  always begin
    @(negedge Clk);
    #2;
    ncyc++;
    if (Reset) begin
      stall_prev = 0;
      last_addr  = 0;
    end else begin
      mon_hs = px_valid && px_ready;
      check("hold_eq_busy", Hold, Busy);
      if (stall_prev) begin
        check("stall_valid", px_valid, 1);
        check("stall_data", px_data, stall_d);
        check("stall_last", px_last, stall_l);
      end
      if (rd_en) begin
        check("rd_addr_order", rd_addr, issued);
        check("rd_addr_range", rd_addr < N_PIX, 1);
        check("rd_credit", (issued - accepted - (mon_hs ? 1 : 0)) < 2, 1);
        issued++;
        last_addr = rd_addr;
      end else begin
        check("rd_addr_hold", rd_addr, last_addr);
      end
      if (px_valid && first_valid_cyc < 0) first_valid_cyc = ncyc;
      if (px_valid) valid_cycles++;
      if (mon_hs) begin
        cap_q.push_back('{int'(px_data), px_last});
        accepted++;
        last_hs_cyc = ncyc;
      end
      if (Done) begin
        done_cnt++;
        done_cyc = ncyc;
      end
      stall_prev = px_valid && !px_ready;
      stall_d    = px_data;
      stall_l    = px_last;
    end
  end

  task automatic clear_frame_stats();
    issued = 0; accepted = 0; cap_q.delete(); valid_cycles = 0;
    first_valid_cyc = -1; last_hs_cyc = -1; done_cyc = -1; done_cnt = 0;
  endtask

  // Runs one frame starting from an idle "+2" sample point.
  task automatic run_frame(input string tag, input int mode, input int stall, input bit spam);
    int cyc, busy_low, bad, lasts, last_idx;
    bit done_seen;
    clear_frame_stats();
    ready_mode = (stall > 0) ? 2 : mode;
    Start = 1'b1;
    @(negedge Clk); #2;                      // cycle after E0
    Start = 1'b0;
    check({tag, "_rd_en_e0"}, rd_en, 1);
    check({tag, "_busy_e0"}, Busy, 1);
    check({tag, "_addr_e0"}, rd_addr, 0);
    check({tag, "_valid_e0"}, px_valid, 0);
    @(negedge Clk); #2;                      // cycle after E1
    check({tag, "_valid_e1"}, px_valid, 0);
    @(negedge Clk); #2;                      // cycle after E2
    check({tag, "_valid_e2"}, px_valid, 1);
    check({tag, "_px0_e2"}, px_data, ref_px(ram[0]));
    cyc = 3; busy_low = 0; done_seen = Done;
    while (!done_seen && cyc < 20000) begin
      if (stall > 0 && cyc == stall) begin
        check({tag, "_stall_reads"}, issued, 2);
        check({tag, "_stall_no_px"}, cap_q.size(), 0);
        ready_mode = mode;
      end
      if (spam) Start = 1'($urandom_range(1));
      @(negedge Clk); #2;
      cyc++;
      if (!Busy || !Hold) busy_low++;
      done_seen = Done;
    end
    check({tag, "_done_seen"}, done_seen, 1);
    check({tag, "_busy_hold_high"}, busy_low, 0);
    Start = spam;                            // sampled at the end of the Done cycle
    @(negedge Clk); #2;
    Start = 1'b0;
    check({tag, "_busy_after_done"}, Busy, 0);
    check({tag, "_done_width"}, Done, 0);
    check({tag, "_rd_en_idle"}, rd_en, 0);
    repeat (3) @(negedge Clk);
    #2;
    check({tag, "_no_retrigger"}, Busy, 0);
    check({tag, "_done_count"}, done_cnt, 1);
    check({tag, "_done_latency"}, done_cyc - last_hs_cyc, 1);
    check({tag, "_px_count"}, cap_q.size(), N_PIX);
    bad = 0; lasts = 0; last_idx = -1;
    for (int i = 0; i < cap_q.size() && i < N_PIX; i++) begin
      if (cap_q[i].d != ref_px(int'(ram[i]))) bad++;
      if (cap_q[i].l) begin lasts++; last_idx = i; end
    end
    check({tag, "_px_mismatches"}, bad, 0);
    check({tag, "_last_count"}, lasts, 1);
    check({tag, "_last_index"}, last_idx, N_PIX - 1);
    if (mode == 0 && stall == 0) begin
      check({tag, "_valid_cycles"}, valid_cycles, N_PIX);
      check({tag, "_valid_run"}, last_hs_cyc - first_valid_cyc, N_PIX - 1);
    end
  endtask

  typedef struct { logic [15:0] word; logic [7:0] px; } conv_vec_t;
  conv_vec_t vecs [8];

  initial begin
    int cyc;
    vecs[0] = '{16'hFFFF, 8'hFF};
    vecs[1] = '{16'h07D0, 8'h07};
    vecs[2] = '{16'h0000, 8'h00};
    vecs[3] = '{16'h00FF, 8'h00};
    vecs[4] = '{16'h0100, 8'h01};
    vecs[5] = '{16'h8000, 8'h80};
    vecs[6] = '{16'h1234, 8'h12};
    vecs[7] = '{16'hABCD, 8'hAB};

    Reset = 1'b1;
    Start = 1'b0;
    repeat (3) @(negedge Clk);
    #2;
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_hold", Hold, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_px_valid", px_valid, 0);
    check("rst_px_data", px_data, 0);
    check("rst_px_last", px_last, 0);
    Reset = 1'b0;
    @(negedge Clk); #2;

    // Ramp pattern, consumer always ready.
    for (int i = 0; i < N_PIX; i++) ram[i] = 16'(i * 83);
    run_frame("ramp", 0, 0, 1'b0);

    // Conversion table, tiled across the frame.
    for (int i = 0; i < N_PIX; i++) ram[i] = vecs[i % 8].word;
    run_frame("conv", 0, 0, 1'b0);
    for (int i = 0; i < 8; i++)
      if (cap_q.size() > i) check("conv_tbl", cap_q[i].d, int'(vecs[i].px));

    // Random data with random backpressure.
    for (int i = 0; i < N_PIX; i++) ram[i] = 16'($urandom_range(65535));
    run_frame("bp", 1, 0, 1'b0);

    // Reset in the middle of a frame.
    clear_frame_stats();
    ready_mode = 0;
    Start = 1'b1;
    @(negedge Clk); #2;
    Start = 1'b0;
    cyc = 0;
    while (accepted < 400 && cyc < 5000) begin
      @(negedge Clk); #2;
      cyc++;
    end
    check("mid_reach_400", accepted >= 400, 1);
    #1 Reset = 1'b1;
    #1;
    check("mid_rst_px_valid", px_valid, 0);
    check("mid_rst_px_data", px_data, 0);
    check("mid_rst_px_last", px_last, 0);
    check("mid_rst_busy", Busy, 0);
    check("mid_rst_hold", Hold, 0);
    check("mid_rst_rd_en", rd_en, 0);
    check("mid_rst_rd_addr", rd_addr, 0);
    @(negedge Clk); #2;
    Reset = 1'b0;
    @(negedge Clk); #2;
    for (int i = 0; i < N_PIX; i++) ram[i] = 16'($urandom_range(65535));
    run_frame("after_rst", 1, 0, 1'b0);

    // Start pulses while streaming and during Done.
    run_frame("spam", 0, 0, 1'b1);

    // Consumer held off for 50 cycles after Start.
    for (int i = 0; i < N_PIX; i++) ram[i] = 16'($urandom_range(65535));
    run_frame("stall50", 0, 50, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog: actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
